alu_op_sequencer: RTL and testbench

Front-end controller for the 16-bit combinational ALU. Accepts one command at a time on a valid/ready interface and drives the ALU function-select (FS, C) and operand inputs from registers. Single-cycle ops take one ALU pass. Multiply is sequenced as a shift-add loop over repeated ALU passes. Returns the result on a valid/ready response interface.

---
 rtl/alu_seq_pkg.sv | 42 ++++
 rtl/alu_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: ALU {FS,C} codes, command opcodes and sequencer states
package alu_seq_pkg;

   localparam int WIDTH_DEF = 16;

   localparam logic [5:0] FSC_ADD    = 6'b101000;
   localparam logic [5:0] FSC_SUB    = 6'b101101;
   localparam logic [5:0] FSC_NEG    = 6'b100011;
   localparam logic [5:0] FSC_AND    = 6'b010000;
   localparam logic [5:0] FSC_OR     = 6'b011100;
   localparam logic [5:0] FSC_XOR    = 6'b001100;
   localparam logic [5:0] FSC_PASS_A = 6'b011000;
   localparam logic [5:0] FSC_SHL    = 6'b110000;
   localparam logic [5:0] FSC_ZERO   = 6'b000000;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_NEG = 3'd5;
   localparam logic [2:0] OP_MUL = 3'd6;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_ISSUE   = 3'd1;
   localparam state_t S_MUL_ADD = 3'd2;
   localparam state_t S_MUL_SHL = 3'd3;
   localparam state_t S_RESP    = 3'd4;

   // Maps a single-pass opcode (0-5) to its ALU {FS,C} code
   function automatic logic [5:0] op_fsc(input logic [2:0] op);
      return (op == OP_ADD) ? FSC_ADD :
             (op == OP_SUB) ? FSC_SUB :
             (op == OP_AND) ? FSC_AND :
             (op == OP_OR)  ? FSC_OR  :
             (op == OP_XOR) ? FSC_XOR :
             (op == OP_NEG) ? FSC_NEG : FSC_ZERO;
   endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command/response front end driving a combinational ALU; MUL via shift-add loop when SEQ_MUL_EN is defined
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEF,
   parameter int MUL_STEPS = WIDTH
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [2:0]       i_cmd_op,
   input  logic [WIDTH-1:0] i_cmd_a,
   input  logic [WIDTH-1:0] i_cmd_b,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [WIDTH-1:0] o_rsp_data,
   output logic             o_rsp_err,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   output logic [4:0]       o_alu_fs,
   output logic             o_alu_c,
   input  logic [WIDTH-1:0] i_alu_out,
   output logic             o_busy
);

   state_t           r_state;
   logic [5:0]       r_fsc;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic             r_rsp_valid;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_err;
   logic             w_accept;
   logic             w_illegal;

   assign w_accept = i_cmd_valid && (r_state == S_IDLE);

`ifdef SEQ_MUL_EN
   localparam int SW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-2:0] r_mplier;
   logic [SW-1:0]    r_step;
   assign w_illegal = (i_cmd_op == 3'd7);
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (MUL_STEPS != 0);
   assign w_illegal = (i_cmd_op >= OP_MUL);
`endif

   // Sequencer FSM: latches commands, steps the ALU and holds the response until taken
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_fsc       <= FSC_ZERO;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
`ifdef SEQ_MUL_EN
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_step      <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_illegal) begin
                     // Errors take one pass-free cycle through ISSUE so all non-MUL ops share the same latency
                     r_rsp_err  <= 1'b1;
                     r_rsp_data <= '0;
                     r_state    <= S_ISSUE;
                  end
`ifdef SEQ_MUL_EN
                  else if (i_cmd_op == OP_MUL) begin
                     r_acc    <= '0;
                     r_mcand  <= i_cmd_a;
                     r_mplier <= i_cmd_b[WIDTH-1:1];
                     r_step   <= '0;
                     r_alu_a  <= '0;
                     r_alu_b  <= i_cmd_a;
                     r_fsc    <= i_cmd_b[0] ? FSC_ADD : FSC_PASS_A;
                     r_state  <= S_MUL_ADD;
                  end
`endif
                  else begin
                     r_alu_a <= i_cmd_a;
                     r_alu_b <= (i_cmd_op == OP_NEG) ? '0 : i_cmd_b;
                     r_fsc   <= op_fsc(i_cmd_op);
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               r_rsp_data  <= r_rsp_err ? '0 : i_alu_out;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
`ifdef SEQ_MUL_EN
            S_MUL_ADD: begin
               r_acc   <= i_alu_out;
               r_alu_a <= r_mcand;
               r_alu_b <= '0;
               r_fsc   <= FSC_SHL;
               r_state <= S_MUL_SHL;
            end
            S_MUL_SHL: begin
               // r_mplier already excludes the bit consumed by the pass just finished
               r_mcand  <= i_alu_out;
               r_mplier <= r_mplier >> 1;
               r_step   <= r_step + SW'(1);
               if (r_step == SW'(MUL_STEPS - 1)) begin
                  r_rsp_data  <= r_acc;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_alu_a <= r_acc;
                  r_alu_b <= i_alu_out;
                  r_fsc   <= r_mplier[0] ? FSC_ADD : FSC_PASS_A;
                  r_state <= S_MUL_ADD;
               end
            end
`endif
            S_RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_alu_a     <= '0;
                  r_alu_b     <= '0;
                  r_fsc       <= FSC_ZERO;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_cmd_ready = (r_state == S_IDLE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_data  = r_rsp_data;
   assign o_rsp_err   = r_rsp_err;
   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_fs    = r_fsc[5:1];
   assign o_alu_c     = r_fsc[0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with behavioural ALU and reference model; honours SEQ_MUL_EN
module tb_alu_op_sequencer;

   localparam int W = 16;
`ifdef SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_op = '0;
   logic [W-1:0] cmd_a = '0;
   logic [W-1:0] cmd_b = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_data;
   logic         rsp_err;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [4:0]   alu_fs;
   logic         alu_c;
   logic [W-1:0] alu_out;
   logic         busy;

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(W), .MUL_STEPS(W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_op(cmd_op), .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .o_rsp_valid(rsp_valid),
      .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fs(alu_fs), .o_alu_c(alu_c),
      .i_alu_out(alu_out), .o_busy(busy)
   );

   // Behavioural 16-bit ALU decoding the {FS,C} function codes
   always_comb begin
      case ({alu_fs, alu_c})
         6'b101000: alu_out = alu_a + alu_b;
         6'b101101: alu_out = alu_a - alu_b;
         6'b100011: alu_out = -alu_a;
         6'b010000: alu_out = alu_a & alu_b;
         6'b011100: alu_out = alu_a | alu_b;
         6'b001100: alu_out = alu_a ^ alu_b;
         6'b011000: alu_out = alu_a;
         6'b110000: alu_out = alu_a << 1;
         default:   alu_out = '0;
      endcase
   end

   typedef struct {
      logic [W-1:0] data;
      logic         err;
      int           due;
      logic [5:0]   fsc;
      bit           chk_fsc;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   seen = 0;
   bit   bp = 0;
   bit   in_rst = 1;
   logic [W-1:0] held_data;
   logic         held_err;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: result of each command from its arithmetic meaning, plus expected latency and ALU code
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int e0);
      exp_t e;
      logic [31:0] p;
      logic [5:0] codes [6];
      codes = '{6'b101000, 6'b101101, 6'b010000, 6'b011100, 6'b001100, 6'b100011};
      e.err = 1'b0;
      e.chk_fsc = 1'b1;
      e.due = e0 + 1;
      e.fsc = (op <= 3'd5) ? codes[op] : 6'b000000;
      case (op)
         3'd0: e.data = a + b;
         3'd1: e.data = a - b;
         3'd2: e.data = a & b;
         3'd3: e.data = a | b;
         3'd4: e.data = a ^ b;
         3'd5: e.data = -a;
         default: e.data = '0;
      endcase
      if (op == 3'd6 && MUL_EN) begin
         p = 32'(a) * 32'(b);
         e.data = p[W-1:0];
         e.due = e0 + 2 * W;
         e.chk_fsc = 1'b0;
      end else if (op >= 3'd6) begin
         e.err = 1'b1;
      end
      return e;
   endfunction

   // Consumer readiness: random unless a test forces backpressure
   initial forever begin
      @(posedge clk);
      #1;
      rsp_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // Monitor: compares each presented response against the scoreboard head
   always @(negedge clk) begin
      if (!in_rst && rsp_valid) begin
         if (q.size() == 0) begin
            chk("rsp_valid_unexpected", {31'd0, rsp_valid}, 32'd0);
         end else begin
            if (!seen) begin
               seen = 1;
               held_data = rsp_data;
               held_err = rsp_err;
               chk("latency", cyc, q[0].due);
               chk("rsp_data", rsp_data, q[0].data);
               chk("rsp_err", rsp_err, q[0].err);
               if (q[0].chk_fsc) chk("alu_fsc", {alu_fs, alu_c}, q[0].fsc);
               if (q[0].err) chk("alu_ab_zero", {alu_a, alu_b}, 32'd0);
            end else begin
               chk("data_stable", rsp_data, held_data);
               chk("err_stable", rsp_err, held_err);
               chk("cmd_ready_in_resp", cmd_ready, 1'b0);
            end
            if (rsp_ready) begin
               void'(q.pop_front());
               seen = 0;
            end
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      @(negedge clk);
      cmd_op = op;
      cmd_a = a;
      cmd_b = b;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_timeout", cmd_ready, 1'b1);
         cmd_valid = 1'b0;
         return;
      end
      q.push_back(model(op, a, b, cyc + 1));
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || !cmd_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_rsp_err"}, rsp_err, 1'b0);
      chk({tag, "_alu_ab"}, {alu_a, alu_b}, 0);
      chk({tag, "_alu_fsc"}, {alu_fs, alu_c}, 0);
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      in_rst = 0;
      @(negedge clk);
      chk("cmd_ready_after_reset", cmd_ready, 1'b1);

      send(3'd0, 16'h1234, 16'h0001);
      send(3'd1, 16'h0005, 16'h0007);
      send(3'd5, 16'h0001, 16'h0000);
      send(3'd4, 16'hF0F0, 16'hFF00);
      send(3'd2, 16'hF0F0, 16'h3C3C);
      send(3'd3, 16'hF000, 16'h000F);
      send(3'd0, 16'hFFFF, 16'h0001);
      send(3'd6, 16'h0012, 16'h0034);
      send(3'd6, 16'h0100, 16'h0100);
      send(3'd6, 16'hFFFF, 16'hFFFF);
      send(3'd7, 16'hABCD, 16'h1234);
      wait_idle();

      // Backpressure: response held 5 cycles while stray commands are offered
      bp = 1;
      send(3'd0, 16'hAAAA, 16'h1111);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid", rsp_valid, 1'b1);
      repeat (5) begin
         cmd_op = 3'd1;
         cmd_a = 16'h5555;
         cmd_b = 16'h0001;
         cmd_valid = ~cmd_valid;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      bp = 0;
      wait_idle();

      // Reset in the middle of an operation aborts it with no response
      bp = 1;
      if (MUL_EN) send(3'd6, 16'h1234, 16'h5678);
      else send(3'd0, 16'h1234, 16'h5678);
      repeat (13) @(negedge clk);
      in_rst = 1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midop_reset");
      q.delete();
      seen = 0;
      @(negedge clk);
      rst_n = 1'b1;
      in_rst = 0;
      bp = 0;
      send(3'd0, 16'h0002, 16'h0003);
      wait_idle();

      repeat (40) send(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
